// File: rtl/sram_req_adapter.sv
// sram_req_adapter
// Front-end for the 1024x32 SRAM wrapper. A valid/ready request channel is
// turned into a single-cycle SRAM access. Read data comes back from the SRAM
// one cycle after issue, is pushed into a small response FIFO, and is
// presented on a valid/ready response channel in request order. Reads are
// issued only when a FIFO slot is reserved for them, so read data is never
// dropped.
//
// Handshake semantics (both channels): a transfer happens in a cycle where
// valid and ready are both 1 at the rising edge. REQ_READY is a function of
// the adapter state, RST and REQ_WE only, and never of REQ_VALID. RSP_VALID is
// a function of the FIFO state only, and never of RSP_READY.
module sram_req_adapter #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int RSP_DEPTH  = 4
) (
  input  logic                    CLK,
  input  logic                    RST,
  // request channel
  input  logic                    REQ_VALID,
  output logic                    REQ_READY,
  input  logic                    REQ_WE,
  input  logic [ADDR_WIDTH-1:0]   REQ_ADDR,
  input  logic [DATA_WIDTH/8-1:0] REQ_WSTRB,
  input  logic [DATA_WIDTH-1:0]   REQ_WDATA,
  // read-response channel
  output logic                    RSP_VALID,
  input  logic                    RSP_READY,
  output logic [DATA_WIDTH-1:0]   RSP_RDATA,
  // SRAM wrapper side
  output logic [ADDR_WIDTH-1:0]   SRAM_ADDR,
  output logic [DATA_WIDTH-1:0]   SRAM_BM,
  output logic [DATA_WIDTH-1:0]   SRAM_DIN,
  output logic                    SRAM_WEN,
  output logic                    SRAM_MEN,
  output logic                    SRAM_REN,
  input  logic [DATA_WIDTH-1:0]   SRAM_DOUT
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int PTR_W  = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CNT_W  = PTR_W + 1;

  // Occupancy limit is compared at CNT_W+1 bits so count + pend never wraps.
  localparam logic [CNT_W:0]   OCC_LIMIT = (CNT_W + 1)'(RSP_DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  // Request-side decode
  logic                  w_accept;
  logic                  w_wr_accept;
  logic                  w_rd_accept;
  logic [DATA_WIDTH-1:0] w_bm_full;
  logic [CNT_W:0]        w_occupancy;

  // Response FIFO state
  logic [DATA_WIDTH-1:0] r_mem [RSP_DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_count;
  logic                  r_pend;
  logic                  w_push;
  logic                  w_pop;

  // Outstanding reads = data already in the FIFO plus the one in the SRAM.
  // A pop in this same cycle is deliberately not credited, which keeps the
  // ready path free of any RSP_READY dependency.
  assign w_occupancy = {1'b0, r_count} + {{CNT_W{1'b0}}, r_pend};

  assign REQ_READY   = !RST && (REQ_WE || (w_occupancy < OCC_LIMIT));
  assign w_accept    = REQ_VALID && REQ_READY;
  assign w_wr_accept = w_accept && REQ_WE;
  assign w_rd_accept = w_accept && !REQ_WE;

  // Expand each byte strobe to eight bit-mask lanes.
  for (genvar g = 0; g < STRB_W; g++) begin : g_bm
    assign w_bm_full[8*g +: 8] = {8{REQ_WSTRB[g]}};
  end

  // SRAM drive: purely combinational from the request accepted this cycle;
  // everything idles at zero when nothing is accepted (including in reset).
  always_comb begin
    SRAM_MEN  = 1'b0;
    SRAM_WEN  = 1'b0;
    SRAM_REN  = 1'b0;
    SRAM_ADDR = '0;
    SRAM_BM   = '0;
    SRAM_DIN  = '0;
    if (w_accept) begin
      SRAM_MEN  = 1'b1;
      SRAM_ADDR = REQ_ADDR;
      if (REQ_WE) begin
        SRAM_WEN = 1'b1;
        SRAM_BM  = w_bm_full;
        SRAM_DIN = REQ_WDATA;
      end else begin
        SRAM_REN = 1'b1;
      end
    end
  end

  // Read-pending flag: marks that SRAM_DOUT carries read data next cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_pend <= 1'b0;
    end else begin
      r_pend <= w_rd_accept;
    end
  end

  assign w_push = r_pend;
  assign w_pop  = RSP_VALID && RSP_READY;

  // FIFO storage: not reset; the head is masked on the output while empty.
  always_ff @(posedge CLK) begin
    if (!RST && w_push) begin
      r_mem[r_wr_ptr] <= SRAM_DOUT;
    end
  end

  // FIFO pointers: natural wrap at RSP_DEPTH (a power of two).
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
    end
  end

  // FIFO occupancy: simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_count <= '0;
    end else if (w_push && !w_pop) begin
      r_count <= r_count + CNT_ONE;
    end else if (w_pop && !w_push) begin
      r_count <= r_count - CNT_ONE;
    end
  end

  assign RSP_VALID = (r_count != '0);
  assign RSP_RDATA = RSP_VALID ? r_mem[r_rd_ptr] : '0;

endmodule
